// File: rtl/tpu_compute_sequencer_pkg.sv
// Shared types and helpers for the TPU compute sequencer and its weight wavefront.
package tpu_package;

  typedef enum logic [2:0] {
    CSEQ_IDLE   = 3'd0,
    CSEQ_WAIT_W = 3'd1,
    CSEQ_PRIME  = 3'd2,
    CSEQ_RUN    = 3'd3,
    CSEQ_DRAIN  = 3'd4
  } cseq_state_e;

  localparam int CSEQ_MUL_SIZE_DEF = 32;

  // Number of anti-diagonals of a square array; also the drain latency.
  function automatic int diag_len(input int mul_size);
    return 2 * mul_size - 1;
  endfunction

  typedef logic [CSEQ_MUL_SIZE_DEF*CSEQ_MUL_SIZE_DEF-1:0] cseq_sel_t;

endpackage

// File: rtl/tpu_compute_sequencer_weight_wavefront.sv
// Diagonal wavefront of weight-buffer selects: a start pulse inverts PE(r,c) at the
// edge r+c cycles later. Overlapping wavefronts are independent toggles. MUL_SIZE >= 2.
module tpu_weight_wavefront
  import tpu_package::*;
#(
  parameter int MUL_SIZE = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic [MUL_SIZE*MUL_SIZE-1:0] weight_sel_o,
  output logic                         busy_o
);

  localparam int DIAG = diag_len(MUL_SIZE);

  logic [DIAG-2:0]              r_tog_pipe;
  logic [MUL_SIZE*MUL_SIZE-1:0] r_sel;
  logic [DIAG-1:0]              w_tog;
  logic [MUL_SIZE*MUL_SIZE-1:0] w_flip;

  // Tap d of the toggle chain fires on diagonal d; tap 0 is the start pulse itself.
  assign w_tog = {r_tog_pipe, start_i};

  for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < MUL_SIZE; gj++) begin : g_col
      assign w_flip[gi*MUL_SIZE+gj] = w_tog[gi+gj];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tog_pipe <= '0;
      r_sel      <= '0;
    end else begin
      r_tog_pipe <= w_tog[DIAG-2:0];
      r_sel      <= r_sel ^ w_flip;
    end
  end

  assign weight_sel_o = r_sel;
  assign busy_o       = |r_tog_pipe;

endmodule

// File: rtl/tpu_compute_sequencer.sv
// Command sequencer for the MUL_SIZE x MUL_SIZE systolic array: tiles, rows, weight
// ping-pong and completion. Optional perf counters under TPU_COMPUTE_PERF_EN.
module tpu_compute_sequencer
  import tpu_package::*;
#(
  parameter int MUL_SIZE  = 32,
  parameter int ROW_W     = 10,
  parameter int TILE_W    = 8,
  parameter int PRIME_CYC = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [ROW_W-1:0]             cmd_rows_i,
  input  logic [TILE_W-1:0]            cmd_tiles_i,
  input  logic                         weights_rdy_i,
  input  logic                         act_valid_i,
  output logic                         weight_consume_o,
  output logic [MUL_SIZE*MUL_SIZE-1:0] weight_sel_o,
  output logic                         act_load_o,
  output logic                         mac_en_o,
  output logic                         stall_o,
  output logic                         tile_last_o,
  output logic                         done_o
`ifdef TPU_COMPUTE_PERF_EN
  ,
  output logic [31:0]                  perf_busy_o,
  output logic [31:0]                  perf_stall_o
`endif
);

  localparam int DRAIN_CYC = diag_len(MUL_SIZE);
  localparam int PC_W      = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

  cseq_state_e          r_state;
  logic [ROW_W-1:0]     r_rows;
  logic [ROW_W-1:0]     r_row;
  logic [TILE_W-1:0]    r_tiles;
  logic [TILE_W-1:0]    r_tile;
  logic [PC_W-1:0]      r_prime_cnt;
  logic                 r_issued;
  logic                 r_zero_done;
  logic [DRAIN_CYC-1:0] r_done_pipe;

  logic w_idle, w_wait, w_run;
  logic w_mac, w_row_last, w_tile_last, w_boundary, w_final;
  logic w_accept, w_zero_cmd, w_swap, w_consume, w_wave_busy;

  assign w_idle      = (r_state == CSEQ_IDLE);
  assign w_wait      = (r_state == CSEQ_WAIT_W);
  assign w_run       = (r_state == CSEQ_RUN);
  assign w_mac       = !rst_i && w_run && act_valid_i;
  assign w_row_last  = (r_row == r_rows - ROW_W'(1));
  assign w_tile_last = (r_tile == r_tiles - TILE_W'(1));
  assign w_boundary  = w_mac && w_row_last;
  assign w_final     = w_boundary && w_tile_last;
  assign w_zero_cmd  = (cmd_rows_i == '0) || (cmd_tiles_i == '0);
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  // A command chained on the final row behaves like one more tile boundary.
  assign w_swap      = w_boundary && weights_rdy_i && (!w_final || (w_accept && !w_zero_cmd));
  assign w_consume   = w_swap || (!rst_i && w_wait && weights_rdy_i);

  assign cmd_ready_o      = !rst_i && (w_idle || w_final);
  assign weight_consume_o = w_consume;
  assign act_load_o       = !rst_i && (w_run || r_state == CSEQ_PRIME);
  assign mac_en_o         = w_mac;
  assign stall_o          = !w_mac;
  assign tile_last_o      = w_boundary;
  assign done_o           = r_done_pipe[DRAIN_CYC-1] || r_zero_done;

  tpu_weight_wavefront #(
    .MUL_SIZE (MUL_SIZE)
  ) u_wavefront (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (w_consume),
    .weight_sel_o (weight_sel_o),
    .busy_o       (w_wave_busy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= CSEQ_IDLE;
      r_rows      <= '0;
      r_row       <= '0;
      r_tiles     <= '0;
      r_tile      <= '0;
      r_prime_cnt <= '0;
      r_issued    <= 1'b0;
      r_zero_done <= 1'b0;
      r_done_pipe <= '0;
    end else begin
      r_zero_done <= w_accept && w_zero_cmd;
      r_done_pipe <= {r_done_pipe[DRAIN_CYC-2:0], w_final};
      if (w_mac) r_issued <= 1'b1;
      case (r_state)
        CSEQ_IDLE: begin
          if (w_accept && !w_zero_cmd) begin
            r_rows   <= cmd_rows_i;
            r_tiles  <= cmd_tiles_i;
            r_row    <= '0;
            r_tile   <= '0;
            r_issued <= 1'b0;
            r_state  <= CSEQ_WAIT_W;
          end
        end
        CSEQ_WAIT_W: begin
          if (weights_rdy_i) begin
            r_prime_cnt <= '0;
            r_state     <= r_issued ? CSEQ_RUN : CSEQ_PRIME;
          end
        end
        CSEQ_PRIME: begin
          if (r_prime_cnt == PC_W'(PRIME_CYC - 1)) r_state <= CSEQ_RUN;
          else r_prime_cnt <= r_prime_cnt + PC_W'(1);
        end
        CSEQ_RUN: begin
          if (w_mac) begin
            if (!w_row_last) begin
              r_row <= r_row + ROW_W'(1);
            end else if (!w_tile_last) begin
              r_row  <= '0;
              r_tile <= r_tile + TILE_W'(1);
              if (!weights_rdy_i) r_state <= CSEQ_WAIT_W;
            end else if (w_accept && !w_zero_cmd) begin
              r_rows  <= cmd_rows_i;
              r_tiles <= cmd_tiles_i;
              r_row   <= '0;
              r_tile  <= '0;
              if (!weights_rdy_i) r_state <= CSEQ_WAIT_W;
            end else begin
              r_state <= CSEQ_DRAIN;
            end
          end
        end
        CSEQ_DRAIN: begin
          // The head stage of the done pipe may fire in the same cycle we leave.
          if (!w_wave_busy && (r_done_pipe[DRAIN_CYC-2:0] == '0)) r_state <= CSEQ_IDLE;
        end
        default: r_state <= CSEQ_IDLE;
      endcase
    end
  end

`ifdef TPU_COMPUTE_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else if (!w_idle) begin
      if (r_perf_busy != '1) r_perf_busy <= r_perf_busy + 32'd1;
      if (stall_o && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_o  = r_perf_busy;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule
